// File: rtl/control_if.sv
// Control-unit bus: instruction/flag inputs from the datapath and the full
// control word plus timing state back out to it.
interface control_if;
  logic        run;
  logic [15:0] IROut;
  logic [3:0]  ALUOutFlag;

  logic [1:0]  RF_OutASel;
  logic [1:0]  RF_OutBSel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_RegSel;
  logic [3:0]  ALU_FunSel;
  logic [1:0]  ARF_OutCSel;
  logic [1:0]  ARF_OutDSel;
  logic [1:0]  ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        IR_LH;
  logic        IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR;
  logic        Mem_CS;
  logic [1:0]  MuxASel;
  logic [1:0]  MuxBSel;
  logic        MuxCSel;
  logic [7:0]  T;
  logic        halted;

  // Controller side
  modport master (
    input  run, IROut, ALUOutFlag,
    output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
           ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
           IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
           MuxASel, MuxBSel, MuxCSel, T, halted
  );

  // Datapath side
  modport slave (
    output run, IROut, ALUOutFlag,
    input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
           ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
           IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
           MuxASel, MuxBSel, MuxCSel, T, halted
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired controller: 3-step fetch/decode/execute (T0 low-byte fetch,
// T1 high-byte fetch, T2 decode+execute) plus a terminal HALT state.
// The control word is a pure decode of state and IROut; it takes effect
// at the rising edge that closes the step.
module control_unit (
  input  logic       clock,
  input  logic       reset,
  control_if.master  bus
);

  typedef enum logic [1:0] {S_T0, S_T1, S_T2, S_HALT} state_t;

  typedef struct packed {
    logic [1:0] rf_outa;
    logic [1:0] rf_outb;
    logic [1:0] rf_fun;
    logic [3:0] rf_reg;
    logic [3:0] alu_fun;
    logic [1:0] arf_outc;
    logic [1:0] arf_outd;
    logic [1:0] arf_fun;
    logic [2:0] arf_reg;
    logic       ir_lh;
    logic       ir_en;
    logic [1:0] ir_fun;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic       mux_c;
  } ctrl_t;

  localparam logic [3:0] OP_LDI = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_BEQ = 4'b0011;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [1:0] FUN_INC  = 2'b01;
  localparam logic [1:0] FUN_LOAD = 2'b10;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [1:0] MUX_ALU  = 2'b00;
  localparam logic [1:0] MUX_IMM  = 2'b10;
  localparam logic [1:0] SEL_PC   = 2'b00;
  localparam logic [2:0] EN_PC    = 3'b011;

  // Everything disabled: no register writes, memory deselected.
  localparam ctrl_t IDLE = '{
    rf_outa: 2'b00, rf_outb: 2'b00, rf_fun: 2'b00, rf_reg: 4'b1111,
    alu_fun: 4'b0000, arf_outc: 2'b00, arf_outd: 2'b00, arf_fun: 2'b00,
    arf_reg: 3'b111, ir_lh: 1'b0, ir_en: 1'b0, ir_fun: 2'b00,
    mem_wr: 1'b0, mem_cs: 1'b1, mux_a: 2'b00, mux_b: 2'b00, mux_c: 1'b0
  };

  state_t     state, state_nxt;
  ctrl_t      cw;
  logic [3:0] opcode;
  logic [1:0] rx, ry;
  logic       flag_z;

  assign opcode = bus.IROut[15:12];
  assign ry     = bus.IROut[11:10];
  assign rx     = bus.IROut[9:8];
  assign flag_z = bus.ALUOutFlag[3];

  // The immediate and the C/N/O flags are consumed by the datapath only.
  logic unused_bits;
  assign unused_bits = ^{bus.IROut[7:0], bus.ALUOutFlag[2:0]};

  // State register; reset wins over everything, including HALT.
  always_ff @(posedge clock) begin
    if (reset) state <= S_T0;
    else       state <= state_nxt;
  end

  // Next-state sequencing; HALT is absorbing and ignores run.
  always_comb begin
    state_nxt = state;
    case (state)
      S_T0:    state_nxt = bus.run ? S_T1 : S_T0;
      S_T1:    state_nxt = S_T2;
      S_T2:    state_nxt = (opcode == OP_HLT) ? S_HALT : S_T0;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_T0;
    endcase
  end

  // Control-word decode; forced idle while reset is held so no write
  // enable can fire during the reset cycle.
  always_comb begin
    cw = IDLE;
    if (!reset) begin
      case (state)
        S_T0, S_T1: begin
          if (state == S_T1 || bus.run) begin
            cw.arf_outd = SEL_PC;
            cw.mem_cs   = 1'b0;
            cw.mem_wr   = 1'b0;
            cw.ir_en    = 1'b1;
            cw.ir_fun   = FUN_LOAD;
            cw.ir_lh    = (state == S_T1);
            cw.arf_reg  = EN_PC;
            cw.arf_fun  = FUN_INC;
          end
        end
        S_T2: begin
          case (opcode)
            OP_LDI: begin
              cw.mux_a      = MUX_IMM;
              cw.rf_fun     = FUN_LOAD;
              cw.rf_reg[rx] = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              cw.rf_outa    = rx;
              cw.rf_outb    = ry;
              cw.mux_c      = 1'b0;
              cw.alu_fun    = (opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
              cw.mux_a      = MUX_ALU;
              cw.rf_fun     = FUN_LOAD;
              cw.rf_reg[rx] = 1'b0;
            end
            OP_BEQ: begin
              // Z as seen during this T2; the branch loads PC with imm.
              if (flag_z) begin
                cw.mux_b   = MUX_IMM;
                cw.arf_fun = FUN_LOAD;
                cw.arf_reg = EN_PC;
              end
            end
            default: ;  // HLT and unused opcodes behave as NOP
          endcase
        end
        default: ;
      endcase
    end
  end

  // Timing-state and status outputs.
  always_comb begin
    bus.T      = 8'h00;
    bus.halted = 1'b0;
    case (state)
      S_T0:    bus.T = 8'h01;
      S_T1:    bus.T = 8'h02;
      S_T2:    bus.T = 8'h04;
      S_HALT:  bus.halted = 1'b1;
      default: bus.T = 8'h00;
    endcase
  end

  assign bus.RF_OutASel  = cw.rf_outa;
  assign bus.RF_OutBSel  = cw.rf_outb;
  assign bus.RF_FunSel   = cw.rf_fun;
  assign bus.RF_RegSel   = cw.rf_reg;
  assign bus.ALU_FunSel  = cw.alu_fun;
  assign bus.ARF_OutCSel = cw.arf_outc;
  assign bus.ARF_OutDSel = cw.arf_outd;
  assign bus.ARF_FunSel  = cw.arf_fun;
  assign bus.ARF_RegSel  = cw.arf_reg;
  assign bus.IR_LH       = cw.ir_lh;
  assign bus.IR_Enable   = cw.ir_en;
  assign bus.IR_Funsel   = cw.ir_fun;
  assign bus.Mem_WR      = cw.mem_wr;
  assign bus.Mem_CS      = cw.mem_cs;
  assign bus.MuxASel     = cw.mux_a;
  assign bus.MuxBSel     = cw.mux_b;
  assign bus.MuxCSel     = cw.mux_c;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: fetch sequencing, each opcode's decode,
// BEQ on both Z values, HALT persistence and reset from mid-fetch/HALT.
module tb_control_unit;
  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  control_if bus ();

  control_unit dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Idle control word check (all fields)
  task automatic chk_idle(input string tag);
    chk({tag, ".rf_reg"},  {12'h0, bus.RF_RegSel},  16'h000f);
    chk({tag, ".arf_reg"}, {13'h0, bus.ARF_RegSel}, 16'h0007);
    chk({tag, ".ir_en"},   {15'h0, bus.IR_Enable},  16'h0000);
    chk({tag, ".mem_cs"},  {15'h0, bus.Mem_CS},     16'h0001);
    chk({tag, ".others"},
        {bus.RF_OutASel, bus.RF_OutBSel, bus.RF_FunSel, bus.ALU_FunSel,
         bus.ARF_FunSel, bus.IR_Funsel, bus.MuxASel}, 16'h0000);
    chk({tag, ".misc"},
        {8'h0, bus.ARF_OutCSel, bus.ARF_OutDSel, bus.MuxBSel, bus.IR_LH,
         bus.Mem_WR}, 16'h0000);
  endtask

  // Starts just after a negedge in T0; ends just after the negedge that
  // enters T2, with run left at 1.
  task automatic fetch();
    bus.run = 1'b1;
    #1;
    chk("t0.T",       {8'h0, bus.T},            16'h0001);
    chk("t0.ir_lh",   {15'h0, bus.IR_LH},       16'h0000);
    chk("t0.arf_reg", {13'h0, bus.ARF_RegSel},  16'h0003);
    chk("t0.arf_fun", {14'h0, bus.ARF_FunSel},  16'h0001);
    chk("t0.ir",      {13'h0, bus.IR_Enable, bus.IR_Funsel}, 16'h0006);
    chk("t0.mem",     {14'h0, bus.Mem_CS, bus.Mem_WR}, 16'h0000);
    @(negedge clock);
    #1;
    chk("t1.T",       {8'h0, bus.T},            16'h0002);
    chk("t1.ir_lh",   {15'h0, bus.IR_LH},       16'h0001);
    chk("t1.arf_reg", {13'h0, bus.ARF_RegSel},  16'h0003);
    chk("t1.ir_en",   {15'h0, bus.IR_Enable},   16'h0001);
    @(negedge clock);
  endtask

  initial begin
    reset          = 1'b1;
    bus.run        = 1'b0;
    bus.IROut      = 16'h0000;
    bus.ALUOutFlag = 4'h0;

    // Reset state
    @(negedge clock); #1;
    chk("rst.T", {8'h0, bus.T}, 16'h0001);
    chk("rst.halted", {15'h0, bus.halted}, 16'h0000);
    chk_idle("rst");
    reset = 1'b0;

    // run = 0 keeps T0 idle
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); #1;
      chk("idle.T", {8'h0, bus.T}, 16'h0001);
      chk("idle.mem_cs", {15'h0, bus.Mem_CS}, 16'h0001);
    end

    // LDI R1,5
    @(negedge clock);
    fetch();
    bus.IROut = 16'h0105; #1;
    chk("ldi.T", {8'h0, bus.T}, 16'h0004);
    chk("ldi.mux_a", {14'h0, bus.MuxASel}, 16'h0002);
    chk("ldi.rf_fun", {14'h0, bus.RF_FunSel}, 16'h0002);
    chk("ldi.rf_reg", {12'h0, bus.RF_RegSel}, 16'h000d);
    chk("ldi.mem_cs", {15'h0, bus.Mem_CS}, 16'h0001);
    @(negedge clock);

    // ADD with Rx=0, Ry=1 (IROut[11:10]=01, IROut[9:8]=00)
    fetch();
    bus.IROut = 16'h1400; #1;
    chk("add.alu", {12'h0, bus.ALU_FunSel}, 16'h0004);
    chk("add.outa", {14'h0, bus.RF_OutASel}, 16'h0000);
    chk("add.outb", {14'h0, bus.RF_OutBSel}, 16'h0001);
    chk("add.rf_reg", {12'h0, bus.RF_RegSel}, 16'h000e);
    chk("add.mux", {13'h0, bus.MuxASel, bus.MuxCSel}, 16'h0000);
    // 16'h1200 decodes by field position as Rx=2, Ry=0
    bus.IROut = 16'h1200; #1;
    chk("add2.sel", {12'h0, bus.RF_OutASel, bus.RF_OutBSel}, 16'h0008);
    chk("add2.rf_reg", {12'h0, bus.RF_RegSel}, 16'h000b);
    @(negedge clock);

    // SUB Rx=3, Ry=1
    fetch();
    bus.IROut = 16'h2700; #1;
    chk("sub.alu", {12'h0, bus.ALU_FunSel}, 16'h0006);
    chk("sub.sel", {12'h0, bus.RF_OutASel, bus.RF_OutBSel}, 16'h000d);
    chk("sub.rf_reg", {12'h0, bus.RF_RegSel}, 16'h0007);
    @(negedge clock);

    // BEQ 0x20, Z = 1 taken; Z = 0 not taken (same T2, flag changed)
    fetch();
    bus.IROut = 16'h3020; bus.ALUOutFlag = 4'b1000; #1;
    chk("beq1.mux_b", {14'h0, bus.MuxBSel}, 16'h0002);
    chk("beq1.arf_fun", {14'h0, bus.ARF_FunSel}, 16'h0002);
    chk("beq1.arf_reg", {13'h0, bus.ARF_RegSel}, 16'h0003);
    chk("beq1.rf_reg", {12'h0, bus.RF_RegSel}, 16'h000f);
    bus.ALUOutFlag = 4'b0111; #1;
    chk_idle("beq0");
    @(negedge clock); #1;
    chk("beq.T", {8'h0, bus.T}, 16'h0001);

    // Unused opcode acts as NOP
    fetch();
    bus.IROut = 16'h5123; bus.ALUOutFlag = 4'h0; #1;
    chk_idle("nop");
    @(negedge clock); #1;
    chk("nop.T", {8'h0, bus.T}, 16'h0001);

    // Reset asserted during T1
    @(negedge clock); #1;
    chk("mid.T", {8'h0, bus.T}, 16'h0002);
    reset = 1'b1; #1;
    chk_idle("mid.rst");
    @(negedge clock);
    reset = 1'b0; bus.run = 1'b0; #1;
    chk("mid.T0", {8'h0, bus.T}, 16'h0001);
    chk_idle("mid.after");

    // HLT
    @(negedge clock);
    fetch();
    bus.IROut = 16'hf000; #1;
    chk_idle("hlt.t2");
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); #1;
      chk("halt.T", {8'h0, bus.T}, 16'h0000);
      chk("halt.halted", {15'h0, bus.halted}, 16'h0001);
      chk("halt.mem_cs", {15'h0, bus.Mem_CS}, 16'h0001);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; #1;
    chk("unhalt.T", {8'h0, bus.T}, 16'h0001);
    chk("unhalt.halted", {15'h0, bus.halted}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
